tcp_vlg_rx_dispatch: RTL and testbench
======================================

Name: tcp_vlg_rx_dispatch

Overview:
- Receive-side counterpart of the TCP transmit arbiter.
- Classifies each parsed TCP segment on an established connection. Emits one-cycle event strobes to the connection controller: remote ACK advance, in-order payload, out-of-order, keep-alive, FIN, RST.
- Generates the held send_ack request (immediate or delayed) that the transmit arbiter services.
- Tracks duplicate ACKs and signals fast retransmit.

Parameters:
ACK_DELAY_TICKS, 200, clock cycles a delayed ACK may be held before send_ack is raised
DUP_ACK_THRESH, 3, duplicate-ACK count that triggers fast_rtx (range 1..7)
VERBOSE, 1, simulation $display of each classified segment
DUT_STRING, "", prefix for VERBOSE messages

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
connected  in  1  connection is in established state
tcb_rem_ip  in  32  remote IPv4 address of connection
tcb_rem_port  in  16  remote port
tcb_loc_port  in  16  local port
loc_ack  in  32  next expected remote sequence number
rem_ack  in  32  highest local sequence number acknowledged by the remote so far
last_seq  in  32  next local sequence number to be sent
rx_val  in  1  one-cycle strobe: header fields valid
rx_err  in  1  checksum/length error, qualifies rx_val
rx_src_ip  in  32  source IP
rx_src_port  in  16  source port
rx_dst_port  in  16  destination port
rx_seq  in  32  sequence number
rx_ack  in  32  acknowledgement number
rx_flags  in  9  TCP flags (bit0 FIN, bit2 RST, bit4 ACK)
rx_wnd  in  16  advertised window
rx_pld_len  in  16  payload length
ack_upd  out  1  strobe: remote ACK advanced
rem_ack_new  out  32  new ACK value, valid with ack_upd
rem_wnd  out  16  last window taken from an accepted segment
pld_ok  out  1  strobe: in-order payload accepted
ooo  out  1  strobe: out-of-order segment (seq after loc_ack)
ka_rcvd  out  1  strobe: keep-alive probe detected
fin_rcvd  out  1  strobe: FIN received
rst_rcvd  out  1  strobe: RST received
fast_rtx  out  1  strobe: duplicate-ACK threshold reached
dup_cnt  out  3  current duplicate-ACK count
send_ack  out  1  request for the transmit arbiter to send a forced ACK
ack_sent  in  1  strobe from the transmit arbiter: forced ACK transmitted

Behaviour:
- Reset: all outputs 0, internal window/timer/count 0, FSM idle_s.
- Qualification: a segment is accepted only if rx_val, !rx_err, connected, rx_src_ip==tcb_rem_ip, rx_src_port==tcb_rem_port and rx_dst_port==tcb_loc_port. Otherwise it is dropped silently.
- Pipeline:
  - idle_s registers the fields on an accepted rx_val, then moves to check_s.
  - check_s drives all strobes for exactly one cycle, then returns to idle_s.
  - Strobe latency is 2 clocks after rx_val.
  - rx_val arriving in check_s is still captured; back-to-back segments lose nothing.
- Sequence compare: modular 32-bit. "a after b" ⇔ signed(a−b) > 0.
- RST flag set: rst_rcvd only. Clears dup_cnt, the delay timer and send_ack. No other classification.
- ACK flag, evaluated in priority order:
  - rx_ack after rem_ack and not after last_seq: ack_upd, rem_ack_new=rx_ack, rem_wnd=rx_wnd, dup_cnt←0.
  - rx_ack==rem_ack, pld_len==0, rx_wnd==rem_wnd, no FIN: dup_cnt increments, saturating at 7. fast_rtx fires in the cycle dup_cnt becomes DUP_ACK_THRESH, once only.
  - rx_ack after last_seq: immediate ACK request, no other effect.
- Payload / sequence, evaluated in priority order:
  - rx_seq==loc_ack and len>0: pld_ok. If the delay timer is idle, start it; if it is already running, make an immediate ACK request (every second segment is ACKed).
  - len≤1 and rx_seq==loc_ack−1: ka_rcvd plus immediate ACK request.
  - rx_seq before loc_ack, other cases: immediate ACK request (duplicate data).
  - rx_seq after loc_ack: ooo plus immediate ACK request.
- FIN flag: fin_rcvd, plus an immediate ACK request.
- Delay timer: counts up to ACK_DELAY_TICKS−1. At expiry it makes an ACK request and stops.
- send_ack handshake:
  - Set by any ACK request; held until ack_sent.
  - ack_sent clears send_ack and the timer.
  - A request in the same cycle as ack_sent wins, so send_ack stays 1.
  - Multiple requests coalesce into one.
- connected deassertion: in the next cycle clear send_ack, the timer and dup_cnt, and force idle_s; a segment in flight is discarded.
- rst asserted mid-operation returns everything to reset values asynchronously.

Test Plan:
- loc_ack=1000; two in-order segments (seq 1000 len 100, then seq 1100 len 100), no ack_sent → pld_ok 2 clocks after each rx_val; send_ack rises right after the second segment's classification, not after the timer.
- Single in-order segment, no second segment → send_ack rises ACK_DELAY_TICKS cycles after pld_ok. ack_sent → send_ack 0 next cycle.
- rem_ack=5000, last_seq=6000; three ACKs with rx_ack=5000, len 0, same window → dup_cnt 1,2,3 and fast_rtx pulses once at 3. Fourth duplicate → dup_cnt 4, no fast_rtx. rx_ack=5500 → ack_upd, rem_ack_new=5500, dup_cnt 0.
- loc_ack=0x00000000, rx_seq=0xFFFFFFFF len 1 → ka_rcvd and send_ack (wrap-around compare). rx_seq=0x00000010 → ooo.
- Segment with wrong src port, and one with rx_err=1 → no strobes. RST segment while send_ack=1 → rst_rcvd, send_ack 0.
- connected drops while the timer is running and dup_cnt=2 → next cycle send_ack 0, dup_cnt 0. Async rst low mid-check_s → all outputs 0 immediately.

Source files
------------

// File: rtl/tcp_vlg_rx_dispatch.sv
// Receive-side dispatcher for an established TCP connection: classifies parsed segments into
// one-cycle event strobes, tracks duplicate ACKs and holds the forced-ACK request for the TX arbiter.
module tcp_vlg_rx_dispatch #(
   parameter int ACK_DELAY_TICKS = 200,
   parameter int DUP_ACK_THRESH  = 3,
   parameter bit VERBOSE         = 1,
   parameter     DUT_STRING      = ""
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        connected,
   input  logic [31:0] tcb_rem_ip,
   input  logic [15:0] tcb_rem_port,
   input  logic [15:0] tcb_loc_port,
   input  logic [31:0] loc_ack,
   input  logic [31:0] rem_ack,
   input  logic [31:0] last_seq,
   input  logic        rx_val,
   input  logic        rx_err,
   input  logic [31:0] rx_src_ip,
   input  logic [15:0] rx_src_port,
   input  logic [15:0] rx_dst_port,
   input  logic [31:0] rx_seq,
   input  logic [31:0] rx_ack,
   input  logic [8:0]  rx_flags,
   input  logic [15:0] rx_wnd,
   input  logic [15:0] rx_pld_len,
   output logic        ack_upd,
   output logic [31:0] rem_ack_new,
   output logic [15:0] rem_wnd,
   output logic        pld_ok,
   output logic        ooo,
   output logic        ka_rcvd,
   output logic        fin_rcvd,
   output logic        rst_rcvd,
   output logic        fast_rtx,
   output logic [2:0]  dup_cnt,
   output logic        send_ack,
   input  logic        ack_sent
);

   localparam int TMR_W = (ACK_DELAY_TICKS > 1) ? $clog2(ACK_DELAY_TICKS) : 1;
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(ACK_DELAY_TICKS - 1);
   localparam logic [2:0] DUP_THR = 3'(DUP_ACK_THRESH);

   typedef enum logic {idle_s, check_s} state_t;

   state_t state, state_nxt;

   logic [31:0] seq_p1, ack_p1;
   logic [15:0] wnd_p1, len_p1;
   logic        fin_p1, rstf_p1, ackf_p1;

   logic             tmr_run;
   logic [TMR_W-1:0] tmr_cnt;
   logic             tmr_exp;

   logic c_upd, c_pld, c_ooo, c_ka, c_fin, c_rst, c_dup, c_req, c_tstart, c_fast;
   logic [2:0] dup_inc;
   logic accept;

   wire unused_cfg = ^{VERBOSE, DUT_STRING, rx_flags[8:5], rx_flags[3], rx_flags[1]};

   // Modular sequence compare: a is after b when the signed distance is positive
   function automatic logic seq_after(input logic [31:0] a, input logic [31:0] b);
      logic signed [31:0] diff;
      diff = signed'(a - b);
      return diff > 0;
   endfunction

   assign accept = rx_val && !rx_err && connected &&
                   rx_src_ip == tcb_rem_ip && rx_src_port == tcb_rem_port &&
                   rx_dst_port == tcb_loc_port;

   // Stage 1: capture header fields of an accepted segment
   always_ff @(posedge clk) begin
      if (accept) begin
         seq_p1  <= rx_seq;
         ack_p1  <= rx_ack;
         wnd_p1  <= rx_wnd;
         len_p1  <= rx_pld_len;
         fin_p1  <= rx_flags[0];
         rstf_p1 <= rx_flags[2];
         ackf_p1 <= rx_flags[4];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= idle_s;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = idle_s;
      case (state)
         idle_s:  if (accept) state_nxt = check_s;
         check_s: if (accept) state_nxt = check_s;
         default: state_nxt = idle_s;
      endcase
   end

   always_comb begin
      c_upd = 1'b0; c_pld = 1'b0; c_ooo = 1'b0; c_ka = 1'b0; c_fin = 1'b0;
      c_rst = 1'b0; c_dup = 1'b0; c_req = 1'b0; c_tstart = 1'b0;
      if (state == check_s && connected) begin
         if (rstf_p1) begin
            c_rst = 1'b1;
         end else begin
            if (ackf_p1) begin
               if (seq_after(ack_p1, rem_ack) && !seq_after(ack_p1, last_seq))
                  c_upd = 1'b1;
               else if (ack_p1 == rem_ack && len_p1 == 16'd0 && wnd_p1 == rem_wnd && !fin_p1)
                  c_dup = 1'b1;
               else if (seq_after(ack_p1, last_seq))
                  c_req = 1'b1;
            end
            // A second in-order segment while the delay timer runs is ACKed at once
            if (seq_p1 == loc_ack && len_p1 != 16'd0) begin
               c_pld = 1'b1;
               if (tmr_run) c_req    = 1'b1;
               else         c_tstart = 1'b1;
            end else if (len_p1 <= 16'd1 && seq_p1 == loc_ack - 32'd1) begin
               c_ka  = 1'b1;
               c_req = 1'b1;
            end else if (seq_after(loc_ack, seq_p1)) begin
               c_req = 1'b1;
            end else if (seq_after(seq_p1, loc_ack)) begin
               c_ooo = 1'b1;
               c_req = 1'b1;
            end
            if (fin_p1) begin
               c_fin = 1'b1;
               c_req = 1'b1;
            end
         end
      end
   end

   assign dup_inc = (dup_cnt == 3'd7) ? 3'd7 : dup_cnt + 3'd1;
   assign c_fast  = c_dup && dup_inc == DUP_THR && dup_cnt != DUP_THR;
   assign tmr_exp = tmr_run && tmr_cnt == TMR_LAST;

   // Stage 2: registered strobes, duplicate-ACK count, delay timer and ACK request
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ack_upd     <= 1'b0;
         pld_ok      <= 1'b0;
         ooo         <= 1'b0;
         ka_rcvd     <= 1'b0;
         fin_rcvd    <= 1'b0;
         rst_rcvd    <= 1'b0;
         fast_rtx    <= 1'b0;
         rem_ack_new <= 32'd0;
         rem_wnd     <= 16'd0;
         dup_cnt     <= 3'd0;
         tmr_run     <= 1'b0;
         tmr_cnt     <= '0;
         send_ack    <= 1'b0;
      end else begin
         ack_upd  <= c_upd;
         pld_ok   <= c_pld;
         ooo      <= c_ooo;
         ka_rcvd  <= c_ka;
         fin_rcvd <= c_fin;
         rst_rcvd <= c_rst;
         fast_rtx <= c_fast;
         if (c_upd) begin
            rem_ack_new <= ack_p1;
            rem_wnd     <= wnd_p1;
         end

         if (!connected || c_rst || c_upd) dup_cnt <= 3'd0;
         else if (c_dup)                   dup_cnt <= dup_inc;

         if (!connected || c_rst) begin
            tmr_run <= 1'b0;
            tmr_cnt <= '0;
         end else if (c_tstart) begin
            tmr_run <= 1'b1;
            tmr_cnt <= '0;
         end else if (ack_sent || tmr_exp) begin
            tmr_run <= 1'b0;
            tmr_cnt <= '0;
         end else if (tmr_run) begin
            tmr_cnt <= tmr_cnt + TMR_W'(1);
         end

         // A new request outranks ack_sent so it is never lost
         if (!connected || c_rst)  send_ack <= 1'b0;
         else if (c_req || tmr_exp) send_ack <= 1'b1;
         else if (ack_sent)        send_ack <= 1'b0;
      end
   end

endmodule

// File: tb/tb_tcp_vlg_rx_dispatch.sv
// Scoreboard bench for tcp_vlg_rx_dispatch: expected strobes are queued with their due cycle
// when a segment is driven and compared by a negedge monitor; ACK-request timing is checked inline.
module tb_tcp_vlg_rx_dispatch;

   localparam int T   = 20;
   localparam int THR = 3;

   localparam logic [6:0] S_NONE = 7'b0000000;
   localparam logic [6:0] S_UPD  = 7'b1000000;
   localparam logic [6:0] S_PLD  = 7'b0100000;
   localparam logic [6:0] S_OOO  = 7'b0010000;
   localparam logic [6:0] S_KA   = 7'b0001000;
   localparam logic [6:0] S_FIN  = 7'b0000100;
   localparam logic [6:0] S_RST  = 7'b0000010;
   localparam logic [6:0] S_FRTX = 7'b0000001;

   logic        clk = 1'b0;
   logic        rst;
   logic        connected;
   logic [31:0] tcb_rem_ip;
   logic [15:0] tcb_rem_port, tcb_loc_port;
   logic [31:0] loc_ack, rem_ack, last_seq;
   logic        rx_val, rx_err;
   logic [31:0] rx_src_ip;
   logic [15:0] rx_src_port, rx_dst_port;
   logic [31:0] rx_seq, rx_ack;
   logic [8:0]  rx_flags;
   logic [15:0] rx_wnd, rx_pld_len;
   logic        ack_upd, pld_ok, ooo, ka_rcvd, fin_rcvd, rst_rcvd, fast_rtx, send_ack, ack_sent;
   logic [31:0] rem_ack_new;
   logic [15:0] rem_wnd;
   logic [2:0]  dup_cnt;

   tcp_vlg_rx_dispatch #(
      .ACK_DELAY_TICKS(T),
      .DUP_ACK_THRESH (THR),
      .VERBOSE        (1'b0)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .connected   (connected),
      .tcb_rem_ip  (tcb_rem_ip),
      .tcb_rem_port(tcb_rem_port),
      .tcb_loc_port(tcb_loc_port),
      .loc_ack     (loc_ack),
      .rem_ack     (rem_ack),
      .last_seq    (last_seq),
      .rx_val      (rx_val),
      .rx_err      (rx_err),
      .rx_src_ip   (rx_src_ip),
      .rx_src_port (rx_src_port),
      .rx_dst_port (rx_dst_port),
      .rx_seq      (rx_seq),
      .rx_ack      (rx_ack),
      .rx_flags    (rx_flags),
      .rx_wnd      (rx_wnd),
      .rx_pld_len  (rx_pld_len),
      .ack_upd     (ack_upd),
      .rem_ack_new (rem_ack_new),
      .rem_wnd     (rem_wnd),
      .pld_ok      (pld_ok),
      .ooo         (ooo),
      .ka_rcvd     (ka_rcvd),
      .fin_rcvd    (fin_rcvd),
      .rst_rcvd    (rst_rcvd),
      .fast_rtx    (fast_rtx),
      .dup_cnt     (dup_cnt),
      .send_ack    (send_ack),
      .ack_sent    (ack_sent)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   typedef struct {
      int          due;
      logic [6:0]  strb;
      logic [2:0]  dup;
      logic [31:0] ack_new;
      logic [15:0] wnd;
      string       tag;
   } exp_t;

   exp_t sb[$];

   wire [6:0] strb = {ack_upd, pld_ok, ooo, ka_rcvd, fin_rcvd, rst_rcvd, fast_rtx};

   always @(negedge clk) begin
      exp_t e;
      while (sb.size() > 0 && sb[0].due < cyc) begin
         e = sb.pop_front();
         chk({e.tag, ".missed_cycle"}, cyc, e.due);
      end
      if (sb.size() > 0 && sb[0].due == cyc) begin
         e = sb.pop_front();
         chk({e.tag, ".strobes"}, strb, e.strb);
         chk({e.tag, ".dup_cnt"}, dup_cnt, e.dup);
         if (e.strb[6]) begin
            chk({e.tag, ".rem_ack_new"}, rem_ack_new, e.ack_new);
            chk({e.tag, ".rem_wnd"}, rem_wnd, e.wnd);
         end
      end else begin
         chk("idle.strobes", strb, S_NONE);
      end
   end

   // Drives one header strobe; called with time just after a rising edge and returns likewise
   task automatic send(input logic [31:0] seq, input logic [31:0] ack, input logic [8:0] flags,
                       input logic [15:0] wnd, input logic [15:0] len, input logic [6:0] es,
                       input logic [2:0] ed, input logic [31:0] eack, input string tag,
                       input bit push);
      exp_t e;
      rx_seq     = seq;
      rx_ack     = ack;
      rx_flags   = flags;
      rx_wnd     = wnd;
      rx_pld_len = len;
      rx_val     = 1'b1;
      if (push) begin
         e.due     = cyc + 2;
         e.strb    = es;
         e.dup     = ed;
         e.ack_new = eack;
         e.wnd     = wnd;
         e.tag     = tag;
         sb.push_back(e);
      end
      @(posedge clk);
      #1;
      rx_val = 1'b0;
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse_ack_sent();
      ack_sent = 1'b1;
      tick(1);
      ack_sent = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, tests=%0d", n_tests);
      $fatal(1, "watchdog");
   end

   initial begin
      rst          = 1'b0;
      connected    = 1'b1;
      tcb_rem_ip   = 32'h0a00_0002;
      tcb_rem_port = 16'd5555;
      tcb_loc_port = 16'd80;
      rx_src_ip    = 32'h0a00_0002;
      rx_src_port  = 16'd5555;
      rx_dst_port  = 16'd80;
      loc_ack      = 32'd0;
      rem_ack      = 32'd0;
      last_seq     = 32'd0;
      rx_val       = 1'b0;
      rx_err       = 1'b0;
      rx_seq       = 32'd0;
      rx_ack       = 32'd0;
      rx_flags     = 9'd0;
      rx_wnd       = 16'd0;
      rx_pld_len   = 16'd0;
      ack_sent     = 1'b0;
      tick(3);
      chk("reset.send_ack", send_ack, 0);
      chk("reset.dup_cnt", dup_cnt, 0);
      chk("reset.rem_wnd", rem_wnd, 0);
      chk("reset.rem_ack_new", rem_ack_new, 0);
      rst = 1'b1;
      tick(2);

      // Two in-order segments: the second forces an immediate ACK
      loc_ack = 32'd1000;
      send(32'd1000, 32'd0, 9'h000, 16'd0, 16'd100, S_PLD, 3'd0, 32'd0, "ino1", 1'b1);
      tick(3);
      chk("t1.no_early_ack", send_ack, 0);
      loc_ack = 32'd1100;
      send(32'd1100, 32'd0, 9'h000, 16'd0, 16'd100, S_PLD, 3'd0, 32'd0, "ino2", 1'b1);
      chk("t1.ack_before_class", send_ack, 0);
      tick(1);
      chk("t1.ack_second_seg", send_ack, 1);
      pulse_ack_sent();
      chk("t1.ack_sent_clears", send_ack, 0);
      tick(T + 2);
      chk("t1.timer_cleared", send_ack, 0);

      // Single in-order segment: delayed ACK after T cycles
      loc_ack = 32'd1200;
      send(32'd1200, 32'd0, 9'h000, 16'd0, 16'd50, S_PLD, 3'd0, 32'd0, "ino3", 1'b1);
      tick(T);
      chk("t2.before_expiry", send_ack, 0);
      tick(1);
      chk("t2.delayed_ack", send_ack, 1);
      pulse_ack_sent();
      chk("t2.ack_sent_clears", send_ack, 0);
      loc_ack = 32'd1250;

      // ACK advance, duplicate ACKs, fast retransmit, ACK beyond last_seq
      rem_ack  = 32'd4000;
      last_seq = 32'd6000;
      send(32'd1250, 32'd5000, 9'h010, 16'd1000, 16'd0, S_UPD, 3'd0, 32'd5000, "adv1", 1'b1);
      tick(2);
      rem_ack = 32'd5000;
      send(32'd1250, 32'd5000, 9'h010, 16'd1000, 16'd0, S_NONE, 3'd1, 32'd0, "dup1", 1'b1);
      send(32'd1250, 32'd5000, 9'h010, 16'd1000, 16'd0, S_NONE, 3'd2, 32'd0, "dup2", 1'b1);
      send(32'd1250, 32'd5000, 9'h010, 16'd1000, 16'd0, S_FRTX, 3'd3, 32'd0, "dup3", 1'b1);
      send(32'd1250, 32'd5000, 9'h010, 16'd1000, 16'd0, S_NONE, 3'd4, 32'd0, "dup4", 1'b1);
      send(32'd1250, 32'd5500, 9'h010, 16'd1000, 16'd0, S_UPD, 3'd0, 32'd5500, "adv2", 1'b1);
      tick(2);
      rem_ack = 32'd5500;
      send(32'd1250, 32'd7000, 9'h010, 16'd1000, 16'd0, S_NONE, 3'd0, 32'd0, "ahead1", 1'b1);
      tick(1);
      chk("t3.ack_ahead_req", send_ack, 1);
      pulse_ack_sent();
      chk("t3.ack_sent_clears", send_ack, 0);

      // Wrap-around keep-alive and out-of-order; request beats a coincident ack_sent
      loc_ack = 32'd0;
      send(32'hFFFF_FFFF, 32'd0, 9'h000, 16'd0, 16'd1, S_KA, 3'd0, 32'd0, "ka", 1'b1);
      tick(1);
      chk("t4.ka_ack_req", send_ack, 1);
      pulse_ack_sent();
      chk("t4.ka_ack_clear", send_ack, 0);
      send(32'h0000_0010, 32'd0, 9'h000, 16'd0, 16'd10, S_OOO, 3'd0, 32'd0, "ooo", 1'b1);
      pulse_ack_sent();
      chk("t4.req_beats_ack_sent", send_ack, 1);
      pulse_ack_sent();
      chk("t4.ooo_ack_clear", send_ack, 0);

      // Dropped segments, FIN, RST clearing a pending request
      rx_src_port = 16'd5556;
      send(32'd0, 32'd0, 9'h000, 16'd0, 16'd10, S_NONE, 3'd0, 32'd0, "badport", 1'b0);
      rx_src_port = 16'd5555;
      rx_err = 1'b1;
      send(32'd0, 32'd0, 9'h001, 16'd0, 16'd10, S_NONE, 3'd0, 32'd0, "rxerr", 1'b0);
      rx_err = 1'b0;
      tick(3);
      chk("t5.dropped_no_ack", send_ack, 0);
      send(32'd0, 32'd0, 9'h001, 16'd0, 16'd0, S_FIN, 3'd0, 32'd0, "fin", 1'b1);
      tick(1);
      chk("t5.fin_ack_req", send_ack, 1);
      send(32'd0, 32'd0, 9'h014, 16'd0, 16'd10, S_RST, 3'd0, 32'd0, "rst", 1'b1);
      tick(1);
      chk("t5.rst_clears_ack", send_ack, 0);

      // Connection drop with timer running, dup_cnt=2 and a pending request
      send(32'd0, 32'd5500, 9'h010, 16'd1000, 16'd0, S_NONE, 3'd1, 32'd0, "dupa", 1'b1);
      send(32'd0, 32'd5500, 9'h010, 16'd1000, 16'd0, S_NONE, 3'd2, 32'd0, "dupb", 1'b1);
      send(32'd0, 32'd5500, 9'h000, 16'd1000, 16'd10, S_PLD, 3'd2, 32'd0, "ino4", 1'b1);
      tick(1);
      loc_ack = 32'd10;
      send(32'd10, 32'd7000, 9'h010, 16'd1000, 16'd0, S_NONE, 3'd2, 32'd0, "ahead2", 1'b1);
      tick(1);
      chk("t6.ack_req", send_ack, 1);
      connected = 1'b0;
      tick(1);
      chk("t6.disc_send_ack", send_ack, 0);
      chk("t6.disc_dup_cnt", dup_cnt, 0);
      connected = 1'b1;
      tick(T + 2);
      chk("t6.timer_cleared", send_ack, 0);

      // Asynchronous reset while a segment sits in the check stage
      send(32'd10, 32'd5500, 9'h010, 16'd1000, 16'd0, S_NONE, 3'd1, 32'd0, "dupc", 1'b1);
      send(32'd10, 32'd7000, 9'h010, 16'd1000, 16'd0, S_NONE, 3'd1, 32'd0, "ahead3", 1'b1);
      tick(1);
      chk("t7.ack_req", send_ack, 1);
      send(32'd10, 32'd0, 9'h000, 16'd0, 16'd10, S_NONE, 3'd0, 32'd0, "inflight", 1'b0);
      rst = 1'b0;
      #1;
      chk("t7.async_send_ack", send_ack, 0);
      chk("t7.async_dup_cnt", dup_cnt, 0);
      chk("t7.async_rem_wnd", rem_wnd, 0);
      chk("t7.async_rem_ack_new", rem_ack_new, 0);
      chk("t7.async_strobes", strb, S_NONE);
      tick(2);
      rst = 1'b1;
      tick(2);
      chk("sb.drained", sb.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
